// File: rtl/system_bus.sv
// ---------------------------------------------------------------------------
// system_bus
//
// Shared single-word bus between N_SRC masters and N_DST loaders. A
// round-robin arbiter picks one requesting source, the word is driven onto
// the bus with a one-hot load strobe to its target, and the transfer ends
// with a one-cycle acknowledge to the source. A target that is out of range,
// or that does not accept the word within TIMEOUT cycles, ends the transfer
// with an error pulse instead of a count.
//
// Ports
//   clk         single clock, rising-edge
//   rst_n       asynchronous active-low reset
//   src_req     per-source transfer request
//   src_data    per-source word, source i at [i*DATA_W +: DATA_W]
//   src_dst     per-source target index, source i at [i*DST_W +: DST_W]
//   src_ack     one-cycle acknowledge to the granted source
//   dst_load    one-hot load strobe to the target destination
//   dst_ready   per-destination accept
//   bus_data    registered bus word, holds last driven value
//   bus_busy    high while a transfer is in progress
//   bus_err     one-cycle error pulse, coincident with src_ack
//   xfer_count  count of successful transfers, wraps
// ---------------------------------------------------------------------------
module system_bus #(
    parameter int DATA_W  = 8,
    parameter int N_SRC   = 3,
    parameter int N_DST   = 3,
    parameter int TIMEOUT = 15,
    localparam int DST_W  = (N_DST > 1) ? $clog2(N_DST) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_SRC-1:0]         src_req,
    input  logic [N_SRC*DATA_W-1:0]  src_data,
    input  logic [N_SRC*DST_W-1:0]   src_dst,
    output logic [N_SRC-1:0]         src_ack,
    output logic [N_DST-1:0]         dst_load,
    input  logic [N_DST-1:0]         dst_ready,
    output logic [DATA_W-1:0]        bus_data,
    output logic                     bus_busy,
    output logic                     bus_err,
    output logic [15:0]              xfer_count
);

    localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    localparam logic [SRC_W:0]     N_SRC_L    = (SRC_W+1)'(N_SRC);
    localparam logic [DST_W:0]     N_DST_L    = (DST_W+1)'(N_DST);
    localparam logic [SRC_W-1:0]   LAST_SRC   = SRC_W'(N_SRC - 1);
    localparam logic [7:0]         TIMEOUT_M1 = 8'(TIMEOUT - 1);
    localparam logic [N_SRC-1:0]   ONE_SRC    = N_SRC'(1);
    localparam logic [N_DST-1:0]   ONE_DST    = N_DST'(1);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        ACK
    } state_t;

    state_t              state, state_next;
    logic [SRC_W-1:0]    grant, grant_next;
    logic [SRC_W-1:0]    rr_ptr, rr_ptr_next;
    logic [DST_W-1:0]    target, target_next;
    logic [7:0]          wait_cnt, wait_cnt_next;
    logic                err_flag, err_flag_next;

    logic [N_SRC-1:0]    src_ack_next;
    logic [N_DST-1:0]    dst_load_next;
    logic [DATA_W-1:0]   bus_data_next;
    logic                bus_busy_next;
    logic                bus_err_next;
    logic [15:0]         xfer_count_next;

    logic [DATA_W-1:0]   src_word [N_SRC];
    logic [DST_W-1:0]    src_tgt  [N_SRC];

    logic                found;
    logic [SRC_W-1:0]    pick;
    logic [SRC_W:0]      cand_sum;

    // Split the flat source buses into per-source words and target indices.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            src_word[i] = src_data[i*DATA_W +: DATA_W];
            src_tgt[i]  = src_dst[i*DST_W +: DST_W];
        end
    end

    // Round-robin search: first requester at or after rr_ptr, wrapping
    // modulo N_SRC. The sum is one bit wider so the wrap subtraction works
    // for non-power-of-two source counts.
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        cand_sum = '0;
        for (int k = 0; k < N_SRC; k++) begin
            cand_sum = {1'b0, rr_ptr} + (SRC_W+1)'(k);
            if (cand_sum >= N_SRC_L) begin
                cand_sum = cand_sum - N_SRC_L;
            end
            if (!found && src_req[cand_sum[SRC_W-1:0]]) begin
                found = 1'b1;
                pick  = cand_sum[SRC_W-1:0];
            end
        end
    end

    // Next-state and next-output logic. Every output is computed here one
    // cycle ahead and registered below, so nothing combinational reaches a
    // port. dst_load defaults to zero and is only re-asserted while waiting.
    always_comb begin
        state_next      = state;
        grant_next      = grant;
        rr_ptr_next     = rr_ptr;
        target_next     = target;
        wait_cnt_next   = wait_cnt;
        err_flag_next   = err_flag;
        src_ack_next    = '0;
        dst_load_next   = '0;
        bus_data_next   = bus_data;
        bus_err_next    = 1'b0;
        xfer_count_next = xfer_count;

        case (state)
            IDLE: begin
                if (found) begin
                    grant_next  = pick;
                    target_next = src_tgt[pick];
                    if ({1'b0, src_tgt[pick]} < N_DST_L) begin
                        state_next    = XFER;
                        dst_load_next = ONE_DST << src_tgt[pick];
                        bus_data_next = src_word[pick];
                        wait_cnt_next = '0;
                    end else begin
                        // No such destination: skip straight to an error ack.
                        state_next    = ACK;
                        err_flag_next = 1'b1;
                    end
                end
            end

            XFER: begin
                if (dst_ready[target]) begin
                    state_next      = ACK;
                    xfer_count_next = xfer_count + 16'd1;
                end else if (wait_cnt == TIMEOUT_M1) begin
                    state_next    = ACK;
                    err_flag_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt + 8'd1;
                    dst_load_next = dst_load;
                end
            end

            ACK: begin
                src_ack_next  = ONE_SRC << grant;
                bus_err_next  = err_flag;
                rr_ptr_next   = (grant == LAST_SRC) ? '0 : grant + SRC_W'(1);
                err_flag_next = 1'b0;
                state_next    = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        bus_busy_next = (state_next != IDLE);
    end

    // State and output registers. Reset aborts any transfer in flight
    // without acknowledging it and restarts arbitration at source 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            rr_ptr     <= '0;
            target     <= '0;
            wait_cnt   <= '0;
            err_flag   <= 1'b0;
            src_ack    <= '0;
            dst_load   <= '0;
            bus_data   <= '0;
            bus_busy   <= 1'b0;
            bus_err    <= 1'b0;
            xfer_count <= '0;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            rr_ptr     <= rr_ptr_next;
            target     <= target_next;
            wait_cnt   <= wait_cnt_next;
            err_flag   <= err_flag_next;
            src_ack    <= src_ack_next;
            dst_load   <= dst_load_next;
            bus_data   <= bus_data_next;
            bus_busy   <= bus_busy_next;
            bus_err    <= bus_err_next;
            xfer_count <= xfer_count_next;
        end
    end

endmodule

// File: tb/tb_system_bus.sv
// ---------------------------------------------------------------------------
// tb_system_bus
//
// Self-checking bench for system_bus with DATA_W=8, N_SRC=3, N_DST=3,
// TIMEOUT=4. Each transfer expectation is queued when its request is driven;
// a negedge monitor compares load strobes and acknowledges against the
// queue head, and the directed sequence checks cycle-exact timing.
// ---------------------------------------------------------------------------
module tb_system_bus;

    localparam int DATA_W  = 8;
    localparam int N_SRC   = 3;
    localparam int N_DST   = 3;
    localparam int TIMEOUT = 4;
    localparam int DST_W   = 2;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N_SRC-1:0]        src_req;
    logic [N_SRC*DATA_W-1:0] src_data;
    logic [N_SRC*DST_W-1:0]  src_dst;
    logic [N_SRC-1:0]        src_ack;
    logic [N_DST-1:0]        dst_load;
    logic [N_DST-1:0]        dst_ready;
    logic [DATA_W-1:0]       bus_data;
    logic                    bus_busy;
    logic                    bus_err;
    logic [15:0]             xfer_count;

    logic [7:0]              word_in [N_SRC];
    logic [1:0]              dst_in  [N_SRC];

    typedef struct {
        logic [1:0] src;
        logic [7:0] data;
        logic [1:0] dst;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int assert_count = 0;
    int fail_count   = 0;

    assign src_data = {word_in[2], word_in[1], word_in[0]};
    assign src_dst  = {dst_in[2], dst_in[1], dst_in[0]};

    system_bus #(
        .DATA_W  (DATA_W),
        .N_SRC   (N_SRC),
        .N_DST   (N_DST),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_req    (src_req),
        .src_data   (src_data),
        .src_dst    (src_dst),
        .src_ack    (src_ack),
        .dst_load   (dst_load),
        .dst_ready  (dst_ready),
        .bus_data   (bus_data),
        .bus_busy   (bus_busy),
        .bus_err    (bus_err),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // Raise a source's request and queue what the bus should do with it.
    task automatic applyStimulus(input logic [1:0] src, input logic [7:0] data,
                                 input logic [1:0] dst, input logic err);
        exp_t e;
        word_in[src] = data;
        dst_in[src]  = dst;
        src_req      = src_req | (3'b001 << src);
        e.src  = src;
        e.data = data;
        e.dst  = dst;
        e.err  = err;
        exp_q.push_back(e);
    endtask

    task automatic releaseSource(input logic [1:0] src);
        src_req = src_req & ~(3'b001 << src);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyReset();
        rst_n     = 1'b0;
        src_req   = '0;
        dst_ready = '0;
        tick(1);
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: any load strobe must match the transfer at the
    // head of the queue, and every acknowledge retires exactly one entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (dst_load !== 3'b000) begin
                if (exp_q.size() == 0) begin
                    checkOutput("load_unexpected", 32'(dst_load), 32'd0);
                end else begin
                    checkOutput("load_target", 32'(dst_load), 32'd1 << exp_q[0].dst);
                    checkOutput("load_data", 32'(bus_data), 32'(exp_q[0].data));
                end
            end
            if (src_ack !== 3'b000) begin
                if (exp_q.size() == 0) begin
                    checkOutput("ack_unexpected", 32'(src_ack), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("ack_src", 32'(src_ack), 32'd1 << mon_e.src);
                    checkOutput("ack_err", 32'(bus_err), 32'(mon_e.err));
                end
            end else if (bus_err !== 1'b0) begin
                checkOutput("err_without_ack", 32'(bus_err), 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        src_req   = '0;
        dst_ready = '0;
        for (int i = 0; i < N_SRC; i++) begin
            word_in[i] = '0;
            dst_in[i]  = '0;
        end
        tick(2);

        $display("[TB] reset state");
        checkOutput("rst_src_ack",    32'(src_ack),    32'd0);
        checkOutput("rst_dst_load",   32'(dst_load),   32'd0);
        checkOutput("rst_bus_data",   32'(bus_data),   32'd0);
        checkOutput("rst_bus_busy",   32'(bus_busy),   32'd0);
        checkOutput("rst_bus_err",    32'(bus_err),    32'd0);
        checkOutput("rst_xfer_count", 32'(xfer_count), 32'd0);
        rst_n = 1'b1;
        tick(1);

        $display("[TB] single transfer");
        applyStimulus(2'd1, 8'hA5, 2'd2, 1'b0);
        dst_ready = 3'b100;
        tick(1);
        checkOutput("single_load", 32'(dst_load), 32'h4);
        checkOutput("single_busy", 32'(bus_busy), 32'd1);
        tick(1);
        checkOutput("single_load_clear", 32'(dst_load), 32'd0);
        checkOutput("single_ack_early",  32'(src_ack),  32'd0);
        tick(1);
        checkOutput("single_ack",   32'(src_ack),    32'h2);
        checkOutput("single_count", 32'(xfer_count), 32'd1);
        releaseSource(2'd1);
        tick(1);
        checkOutput("single_ack_pulse", 32'(src_ack),  32'd0);
        checkOutput("single_idle",      32'(bus_busy), 32'd0);
        checkOutput("single_bus_hold",  32'(bus_data), 32'hA5);

        $display("[TB] backpressure");
        applyStimulus(2'd0, 8'h5C, 2'd0, 1'b0);
        dst_ready = 3'b110;
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            checkOutput("bp_load_hold", 32'(dst_load), 32'h1);
        end
        dst_ready = 3'b111;
        tick(1);
        checkOutput("bp_load_clear", 32'(dst_load), 32'd0);
        tick(1);
        checkOutput("bp_ack",   32'(src_ack),    32'h1);
        checkOutput("bp_err",   32'(bus_err),    32'd0);
        checkOutput("bp_count", 32'(xfer_count), 32'd2);
        releaseSource(2'd0);
        tick(1);

        $display("[TB] timeout");
        applyStimulus(2'd1, 8'h7E, 2'd1, 1'b1);
        dst_ready = 3'b101;
        for (int i = 1; i <= TIMEOUT; i++) begin
            tick(1);
            checkOutput("to_load_hold", 32'(dst_load), 32'h2);
        end
        tick(1);
        checkOutput("to_load_clear", 32'(dst_load), 32'd0);
        tick(1);
        checkOutput("to_ack",   32'(src_ack),    32'h2);
        checkOutput("to_err",   32'(bus_err),    32'd1);
        checkOutput("to_count", 32'(xfer_count), 32'd2);
        releaseSource(2'd1);
        tick(1);
        checkOutput("to_err_pulse", 32'(bus_err), 32'd0);

        $display("[TB] bad target");
        applyStimulus(2'd0, 8'h99, 2'd3, 1'b1);
        dst_ready = 3'b111;
        tick(1);
        checkOutput("bad_no_load",  32'(dst_load), 32'd0);
        checkOutput("bad_busy",     32'(bus_busy), 32'd1);
        checkOutput("bad_bus_hold", 32'(bus_data), 32'h7E);
        tick(1);
        checkOutput("bad_ack",   32'(src_ack),    32'h1);
        checkOutput("bad_err",   32'(bus_err),    32'd1);
        checkOutput("bad_count", 32'(xfer_count), 32'd2);
        releaseSource(2'd0);
        tick(1);
        checkOutput("queue_drained_a", 32'(exp_q.size()), 32'd0);

        $display("[TB] contention");
        applyReset();
        applyStimulus(2'd0, 8'h11, 2'd0, 1'b0);
        applyStimulus(2'd1, 8'h22, 2'd1, 1'b0);
        applyStimulus(2'd2, 8'h33, 2'd2, 1'b0);
        applyStimulus(2'd0, 8'h11, 2'd0, 1'b0);
        dst_ready = 3'b111;
        for (int c = 1; c <= 12; c++) begin
            tick(1);
            if (c % 3 == 0) begin
                checkOutput("cont_count", 32'(xfer_count), 32'(c / 3));
            end
        end
        checkOutput("cont_last_ack", 32'(src_ack), 32'h1);
        src_req = '0;
        tick(1);
        checkOutput("cont_idle", 32'(bus_busy), 32'd0);
        checkOutput("queue_drained_b", 32'(exp_q.size()), 32'd0);

        $display("[TB] reset mid-transfer");
        applyReset();
        applyStimulus(2'd0, 8'h44, 2'd0, 1'b0);
        word_in[2] = 8'hC3;
        dst_in[2]  = 2'd2;
        src_req    = src_req | 3'b100;
        dst_ready  = 3'b000;
        tick(1);
        checkOutput("mid_load", 32'(dst_load), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_load",  32'(dst_load),   32'd0);
        checkOutput("mid_rst_data",  32'(bus_data),   32'd0);
        checkOutput("mid_rst_busy",  32'(bus_busy),   32'd0);
        checkOutput("mid_rst_ack",   32'(src_ack),    32'd0);
        checkOutput("mid_rst_count", 32'(xfer_count), 32'd0);
        exp_q.delete();
        releaseSource(2'd0);
        begin
            exp_t e;
            e.src  = 2'd2;
            e.data = 8'hC3;
            e.dst  = 2'd2;
            e.err  = 1'b0;
            exp_q.push_back(e);
        end
        tick(2);
        checkOutput("mid_rst_no_ack", 32'(src_ack), 32'd0);
        rst_n     = 1'b1;
        dst_ready = 3'b100;
        tick(1);
        checkOutput("mid_regrant_load", 32'(dst_load), 32'h4);
        tick(2);
        checkOutput("mid_regrant_ack",   32'(src_ack),    32'h4);
        checkOutput("mid_regrant_count", 32'(xfer_count), 32'd1);
        releaseSource(2'd2);
        tick(1);
        checkOutput("queue_drained_c", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
